cnu_wr_update_handshake: RTL and testbench



---
 rtl/cnu_wr_update_handshake_if.sv | 28 ++
 rtl/cnu_wr_update_handshake.sv | 123 ++++++++++++
 tb/tb_cnu_wr_update_handshake.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cnu_wr_update_handshake_if.sv
// Handshake bundle between the CNU load side and the CNU write/update side.
// The slave modport is the controller view; the master modport drives the requests and writer flag.
interface cnu_wr_update_handshake_if;
    logic cnu_init_load_en_i;
    logic cnu_rd_finish_i;
    logic iter_update_i;
    logic init_load_o;
    logic pipe_load_o;
    logic cnu_wr_o;

    modport slave (
        input  cnu_init_load_en_i,
        input  cnu_rd_finish_i,
        input  iter_update_i,
        output init_load_o,
        output pipe_load_o,
        output cnu_wr_o
    );

    modport master (
        output cnu_init_load_en_i,
        output cnu_rd_finish_i,
        output iter_update_i,
        input  init_load_o,
        input  pipe_load_o,
        input  cnu_wr_o
    );
endinterface

// File: rtl/cnu_wr_update_handshake.sv
// CNU load/write handshake: request -> fixed-length load strobe -> writer grant -> four-phase release.
// Define CNU_WR_HS_SYNC_EN to pass both request inputs through 2-flop synchronizers.
module cnu_wr_update_handshake #(
    parameter int unsigned LOAD_CYCLES = 2
) (
    input logic                        write_clk,
    input logic                        rst,
    cnu_wr_update_handshake_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrReq,
        StWrBusy,
        StRelease
    } state_e;

    localparam logic       KindInit = 1'b0;
    localparam logic       KindPipe = 1'b1;
    localparam logic [3:0] CntLoad  = 4'(LOAD_CYCLES - 1);

    logic       req_init;
    logic       req_pipe;
    state_e     state_q, state_d;
    logic       kind_q, kind_d;
    logic [3:0] cnt_q, cnt_d;
    logic       init_load_q, init_load_d;
    logic       pipe_load_q, pipe_load_d;
    logic       cnu_wr_q, cnu_wr_d;

`ifdef CNU_WR_HS_SYNC_EN
    logic [1:0] init_sync_q;
    logic [1:0] pipe_sync_q;

    always_ff @(posedge write_clk) begin
        if (rst) begin
            init_sync_q <= 2'b00;
            pipe_sync_q <= 2'b00;
        end else begin
            init_sync_q <= {init_sync_q[0], bus.cnu_init_load_en_i};
            pipe_sync_q <= {pipe_sync_q[0], bus.cnu_rd_finish_i};
        end
    end

    assign req_init = init_sync_q[1];
    assign req_pipe = pipe_sync_q[1];
`else
    assign req_init = bus.cnu_init_load_en_i;
    assign req_pipe = bus.cnu_rd_finish_i;
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_init) begin
                    kind_d  = KindInit;
                    cnt_d   = CntLoad;
                    state_d = StLoad;
                end else if (req_pipe) begin
                    kind_d  = KindPipe;
                    cnt_d   = CntLoad;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWrReq;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrReq: begin
                if (bus.iter_update_i) begin
                    state_d = StWrBusy;
                end
            end
            StWrBusy: begin
                if (!bus.iter_update_i) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Only the request that opened this transaction gates the exit.
                if ((kind_q == KindInit) ? !req_init : !req_pipe) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they leave the block as plain flops.
        init_load_d = (state_d == StLoad) && (kind_d == KindInit);
        pipe_load_d = (state_d == StLoad) && (kind_d == KindPipe);
        cnu_wr_d    = (state_d == StWrReq) || (state_d == StWrBusy);
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            kind_q      <= KindInit;
            cnt_q       <= 4'd0;
            init_load_q <= 1'b0;
            pipe_load_q <= 1'b0;
            cnu_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            init_load_q <= init_load_d;
            pipe_load_q <= pipe_load_d;
            cnu_wr_q    <= cnu_wr_d;
        end
    end

    assign bus.init_load_o = init_load_q;
    assign bus.pipe_load_o = pipe_load_q;
    assign bus.cnu_wr_o    = cnu_wr_q;

endmodule

// File: tb/tb_cnu_wr_update_handshake.sv
// Directed bench for cnu_wr_update_handshake with LOAD_CYCLES = 2: a per-cycle vector table
// plus hand-written sequences for the long write burst, release hold and mid-write reset.
module tb_cnu_wr_update_handshake;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cnu_wr_update_handshake_if bus ();

    cnu_wr_update_handshake #(
        .LOAD_CYCLES(2)
    ) dut (
        .write_clk(clk),
        .rst      (rst),
        .bus      (bus)
    );

    typedef struct {
        logic r;
        logic i;
        logic p;
        logic u;
        logic ei;
        logic ep;
        logic ew;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic r, i, p, u, ei, ep, ew);
        vec_t v;
        v.r = r; v.i = i; v.p = p; v.u = u;
        v.ei = ei; v.ep = ep; v.ew = ew;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic r, i, p, u);
        @(negedge clk);
        rst                    = r;
        bus.cnu_init_load_en_i = i;
        bus.cnu_rd_finish_i    = p;
        bus.iter_update_i      = u;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic ei, ep, ew);
        checks++;
        if ({bus.init_load_o, bus.pipe_load_o, bus.cnu_wr_o} !== {ei, ep, ew}) begin
            failures++;
            $display("FAIL %s: init/pipe/wr got %b%b%b expected %b%b%b", name,
                     bus.init_load_o, bus.pipe_load_o, bus.cnu_wr_o, ei, ep, ew);
        end
    endtask

    initial begin
        rst                    = 1'b1;
        bus.cnu_init_load_en_i = 1'b0;
        bus.cnu_rd_finish_i    = 1'b0;
        bus.iter_update_i      = 1'b0;

        //                 rst ini rd  upd  ei  ep  ew
        // Reset held with both requests high, then init wins.
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        // Init released: pipe serviced from IDLE.
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
        // Pipe request dropped during write: release exits on its first cycle.
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // iter_update_i already high during LOAD advances WR_REQ on the next edge.
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].r, vecs[k].i, vecs[k].p, vecs[k].u);
            chk($sformatf("vec%0d", k), vecs[k].ei, vecs[k].ep, vecs[k].ew);
        end

        // Init load with a 32-cycle writer burst, then a 20-cycle release hold.
        drive(0, 1, 0, 0); chk("burst_load1", 1, 0, 0);
        drive(0, 1, 0, 0); chk("burst_load2", 1, 0, 0);
        drive(0, 1, 0, 0); chk("burst_wrreq", 0, 0, 1);
        for (int k = 0; k < 32; k++) begin
            drive(0, 1, 0, 1);
            chk($sformatf("burst_busy%0d", k), 0, 0, 1);
        end
        drive(0, 1, 0, 0); chk("burst_end", 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 0, 0);
            chk($sformatf("release_hold%0d", k), 0, 0, 0);
        end
        drive(0, 0, 0, 0); chk("release_exit", 0, 0, 0);
        drive(0, 0, 0, 0); chk("release_idle", 0, 0, 0);

        // Reset while the writer is busy aborts the grant at once.
        drive(0, 1, 0, 0); chk("mr_load1", 1, 0, 0);
        drive(0, 1, 0, 0); chk("mr_load2", 1, 0, 0);
        drive(0, 1, 0, 0); chk("mr_wrreq", 0, 0, 1);
        drive(0, 1, 0, 1); chk("mr_busy", 0, 0, 1);
        drive(1, 1, 0, 1); chk("mr_reset", 0, 0, 0);
        drive(1, 0, 0, 0); chk("mr_reset2", 0, 0, 0);
        drive(0, 0, 1, 0); chk("mr_pipe1", 0, 1, 0);
        drive(0, 0, 1, 0); chk("mr_pipe2", 0, 1, 0);
        drive(0, 0, 1, 0); chk("mr_wrreq2", 0, 0, 1);
        drive(0, 0, 1, 1); chk("mr_busy2", 0, 0, 1);
        drive(0, 0, 0, 0); chk("mr_release", 0, 0, 0);
        drive(0, 0, 0, 0); chk("mr_idle", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
